// File: rtl/accum_arb_pkg.sv
// accum_arb_pkg: shared state encoding and default width for the accumulate arbiter.
package accum_arb_pkg;
  localparam int WIDTH_DEF = 8;
  typedef enum logic [1:0] {IDLE, LOAD, ADD, DONE} state_t;
endpackage

// File: rtl/accum_datapath.sv
// accum_datapath: operand mux/register, adder with carry-out, accumulator with sticky overflow.
module accum_datapath
  import accum_arb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sel,
  input  logic             load,
  input  logic             add_en,
  input  logic             clear,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  output logic [WIDTH-1:0] acc,
  output logic             overflow
);
  logic [WIDTH-1:0] operand;
  logic [WIDTH:0]   sum;
  assign sum = {1'b0, acc} + {1'b0, operand};
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      operand  <= '0;
      acc      <= '0;
      overflow <= 1'b0;
    end else begin
      if (load) operand <= sel ? d1 : d0;
      if (clear) begin
        acc      <= '0;
        overflow <= 1'b0;
      end else if (add_en) begin
        acc      <= sum[WIDTH-1:0];
        overflow <= overflow | sum[WIDTH];
      end
    end
endmodule

// File: rtl/accum_arbiter.sv
// accum_arbiter: round-robin FSM sharing one accumulate datapath between two requesters.
module accum_arbiter
  import accum_arb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  input  logic [WIDTH-1:0] req0_data,
  input  logic [WIDTH-1:0] req1_data,
  input  logic             clear,
  output logic [1:0]       req_ready,
  output logic [1:0]       grant,
  output logic             sel,
  output logic [WIDTH-1:0] acc_out,
  output logic             result_valid,
  output logic             overflow
);
  state_t state;
  logic   last_grant;
  logic   win;
  // on a tie the requester that did not complete last goes first
  assign win = &req_valid ? ~last_grant : req_valid[1];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state      <= IDLE;
      grant      <= '0;
      sel        <= 1'b0;
      last_grant <= 1'b1;
    end else if (clear) begin
      state <= IDLE;
      grant <= '0;
    end else
      case (state)
        IDLE: if (|req_valid) begin
          state <= LOAD;
          sel   <= win;
          grant <= win ? 2'b10 : 2'b01;
        end
        LOAD: state <= ADD;
        ADD: begin
          state      <= DONE;
          last_grant <= sel;
        end
        DONE: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
  assign req_ready    = (state == LOAD && !clear) ? grant : 2'b00;
  assign result_valid = state == DONE;
  accum_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk      (clk),
    .reset    (reset),
    .sel      (sel),
    .load     (state == LOAD && !clear),
    .add_en   (state == ADD && !clear),
    .clear    (clear),
    .d0       (req0_data),
    .d1       (req1_data),
    .acc      (acc_out),
    .overflow (overflow)
  );
endmodule

// File: tb/tb_accum_arbiter.sv
// tb_accum_arbiter: directed and random transactions checked against a transaction-timeline model.
module tb_accum_arbiter;
  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req_valid;
  logic [7:0] req0_data, req1_data;
  logic       clear;
  logic [1:0] req_ready, grant;
  logic       sel, result_valid, overflow;
  logic [7:0] acc_out;

  accum_arbiter dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req0_data(req0_data),
    .req1_data(req1_data), .clear(clear), .req_ready(req_ready), .grant(grant),
    .sel(sel), .acc_out(acc_out), .result_valid(result_valid), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  // model: m_t counts cycles since a grant was issued (0 = free)
  int         m_t;
  int         m_acc;
  logic       m_ovf, m_last, m_win, m_sel;
  int         m_op;
  logic [1:0] refill;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_t = 0; m_acc = 0; m_ovf = 0; m_last = 1; m_win = 0; m_sel = 0; m_op = 0;
  endtask

  task automatic step();
    logic [1:0] oh;
    #1;
    oh = m_win ? 2'b10 : 2'b01;
    chk("acc_out", acc_out, 8'(m_acc));
    chk("overflow", {7'd0, overflow}, {7'd0, m_ovf});
    chk("req_ready", {6'd0, req_ready}, (m_t == 1 && !clear) ? {6'd0, oh} : 8'd0);
    chk("grant", {6'd0, grant}, m_t != 0 ? {6'd0, oh} : 8'd0);
    chk("sel", {7'd0, sel}, {7'd0, m_sel});
    chk("result_valid", {7'd0, result_valid}, {7'd0, m_t == 3});
    @(negedge clk);
    if (clear) begin
      m_acc = 0; m_ovf = 0; m_t = 0;
    end else if (m_t == 0) begin
      if (req_valid != 2'b00) begin
        m_win = (req_valid == 2'b11) ? ~m_last : req_valid[1];
        m_sel = m_win;
        m_t = 1;
      end
    end else if (m_t == 1) begin
      m_op = m_win ? int'(req1_data) : int'(req0_data);
      req_valid[m_win] = refill[m_win];
      m_t = 2;
    end else if (m_t == 2) begin
      m_acc = m_acc + m_op;
      if (m_acc > 255) m_ovf = 1'b1;
      m_acc = m_acc % 256;
      m_last = m_win;
      m_t = 3;
    end else m_t = 0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    reset = 1'b0; req_valid = 2'b00; req0_data = 8'h00; req1_data = 8'h00;
    clear = 1'b0; refill = 2'b00;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst acc", acc_out, 8'h00);
    chk("rst ready", {6'd0, req_ready}, 8'd0);
    chk("rst grant", {6'd0, grant}, 8'd0);
    chk("rst rv", {7'd0, result_valid}, 8'd0);
    @(negedge clk);
    reset = 1'b1;
    step();
    // single request from requester 0
    req_valid = 2'b01; req0_data = 8'h05;
    steps(3);
    #1;
    chk("single acc", acc_out, 8'h05);
    chk("single rv", {7'd0, result_valid}, 8'd1);
    steps(2);
    // tie between both requesters
    pulse_clear();
    req_valid = 2'b11; req0_data = 8'h10; req1_data = 8'h20;
    steps(9);
    chk("tie acc", acc_out, 8'h30);
    // overflow and sticky flag
    pulse_clear();
    req_valid = 2'b01; req0_data = 8'hF0; steps(4);
    req_valid = 2'b01; req0_data = 8'h20; steps(4);
    chk("wrap acc", acc_out, 8'h10);
    chk("wrap ovf", {7'd0, overflow}, 8'd1);
    req_valid = 2'b01; req0_data = 8'h01; steps(4);
    chk("sticky ovf", {7'd0, overflow}, 8'd1);
    // clear during ADD, then clear during LOAD
    req_valid = 2'b10; req1_data = 8'h07;
    steps(2);
    pulse_clear();
    step();
    chk("clr add acc", acc_out, 8'h00);
    req_valid = 2'b01; req0_data = 8'h09;
    step();
    pulse_clear();
    steps(5);
    chk("clr load acc", acc_out, 8'h09);
    steps(2);
    // asynchronous reset while in LOAD
    req_valid = 2'b11; req0_data = 8'h11; req1_data = 8'h22;
    step();
    #2 reset = 1'b0;
    #1;
    chk("arst acc", acc_out, 8'h00);
    chk("arst ovf", {7'd0, overflow}, 8'd0);
    chk("arst ready", {6'd0, req_ready}, 8'd0);
    chk("arst grant", {6'd0, grant}, 8'd0);
    chk("arst sel", {7'd0, sel}, 8'd0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    step();
    chk("arst tie grant", {6'd0, grant}, 8'h01);
    steps(8);
    // back-to-back single requester
    pulse_clear();
    req_valid = 2'b10; req1_data = 8'h03; refill = 2'b10;
    steps(12);
    req_valid = 2'b00; refill = 2'b00;
    chk("b2b acc", acc_out, 8'h09);
    // random traffic with occasional clears
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++)
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          if (i == 0) req0_data = 8'($urandom);
          else req1_data = 8'($urandom);
          req_valid[i] = 1'b1;
        end
      clear = $urandom_range(0, 11) == 0;
      step();
    end
    clear = 1'b0;
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
